mem_port_arbiter: RTL

- Shares the single physical-memory port between the I-cache (line fills for the fetch stage) and the D-cache (fills and write-backs for the MEM stage).
- Data misses win by default because they belong to the older instruction.
- A starvation guard forces an instruction grant so fetch cannot stall indefinitely.
- Exports a saturating conflict counter alongside the pipeline's existing stall counters.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one physical-memory port between the I-cache (line fills) and the
//   D-cache (fills and write-backs). D requests win by default because they
//   belong to the older instruction. A starvation guard hands the next
//   contested grant to I after STARVE_LIMIT consecutive D grants made while I
//   was waiting. A saturating counter records contested grant decisions.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   icache_read/address   : I-cache fill request (held until icache_resp)
//   icache_resp/rdata     : one-cycle completion pulse, fill data
//   dcache_read/write     : D-cache fill / write-back request (held until resp)
//   dcache_address/wdata  : D request address and write-back data
//   dcache_resp/rdata     : one-cycle completion pulse, fill data
//   pmem_*                : physical memory port
//   conflict_count_reset  : synchronous clear of conflict_count
//   conflict_count        : saturating count of contested decisions
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LINE_W       = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_read,
    input  logic [15:0]       icache_address,
    output logic              icache_resp,
    output logic [LINE_W-1:0] icache_rdata,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [15:0]       dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic              dcache_resp,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              conflict_count_reset,
    output logic [15:0]       conflict_count
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] STARVE_ONE = SC_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;

    logic [1:0]        r_state;
    logic [15:0]       r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_d_write;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [15:0]       r_conflict_count;

    logic w_d_pend;
    logic w_conflict;
    logic w_grant_i;
    logic w_grant_d;

    assign w_d_pend   = dcache_read | dcache_write;
    assign w_conflict = (r_state == ST_IDLE) & icache_read & w_d_pend;

    // Grant decision is only taken in IDLE; the mandatory IDLE cycle after
    // every transfer lets the finished requester drop its request first.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (icache_read && w_d_pend) begin
                if (r_starve_cnt == STARVE_MAX) begin
                    w_grant_i = 1'b1;
                end else begin
                    w_grant_d = 1'b1;
                end
            end else if (icache_read) begin
                w_grant_i = 1'b1;
            end else if (w_d_pend) begin
                w_grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_d_write    <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_i) begin
                        r_state      <= ST_SERVE_I;
                        r_addr       <= icache_address;
                        r_wdata      <= dcache_wdata;
                        r_d_write    <= 1'b0;
                        r_starve_cnt <= '0;
                    end else if (w_grant_d) begin
                        r_state   <= ST_SERVE_D;
                        r_addr    <= dcache_address;
                        r_wdata   <= dcache_wdata;
                        // read+write together is treated as a write-back
                        r_d_write <= dcache_write;
                        if (icache_read && (r_starve_cnt != STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + STARVE_ONE;
                        end
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_count <= '0;
        end else if (conflict_count_reset) begin
            r_conflict_count <= '0;
        end else if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    // Strobes come from state so an asynchronous reset drops them at once.
    assign pmem_read    = (r_state == ST_SERVE_I) | ((r_state == ST_SERVE_D) & ~r_d_write);
    assign pmem_write   = (r_state == ST_SERVE_D) & r_d_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;

    assign icache_resp  = (r_state == ST_SERVE_I) & pmem_resp;
    assign dcache_resp  = (r_state == ST_SERVE_D) & pmem_resp;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

    assign conflict_count = r_conflict_count;

endmodule
